dmi_arbiter: RTL and testbench

Two-port arbiter sharing a single Debug Module Interface (DMI) slave between two debug requesters: the JTAG DTM and the host-side debug bridge. Each port captures one pulse-initiated request. Grants are round-robin, one transaction in flight at a time. The DM response is routed back to the originating port. Sits between the requesters and the debug module, in the debug clock domain.

---
 rtl/dmi_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_dmi_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_arbiter.sv
// Two-port round-robin arbiter in front of a single DMI slave; one transaction in flight.
// Optional macro DMI_ARB_TIMEOUT_EN adds an m_ack wait limit of TIMEOUT cycles.
module dmi_arbiter #(
    parameter int ABITS   = 7,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             trst_n,
    input  logic             s0_req,
    input  logic [ABITS-1:0] s0_addr,
    input  logic [31:0]      s0_wdata,
    input  logic [1:0]       s0_op,
    output logic             s0_ack,
    output logic [31:0]      s0_rdata,
    output logic [1:0]       s0_resp,
    output logic             s0_ovf,
    input  logic             s1_req,
    input  logic [ABITS-1:0] s1_addr,
    input  logic [31:0]      s1_wdata,
    input  logic [1:0]       s1_op,
    output logic             s1_ack,
    output logic [31:0]      s1_rdata,
    output logic [1:0]       s1_resp,
    output logic             s1_ovf,
    input  logic             ovf_clr,
    output logic             m_req,
    output logic [ABITS-1:0] m_addr,
    output logic [31:0]      m_wdata,
    output logic [1:0]       m_op,
    input  logic [31:0]      m_rdata,
    input  logic [1:0]       m_resp,
    input  logic             m_ack,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    function automatic logic op_valid(input logic [1:0] op);
        return (op == 2'd1) || (op == 2'd2);
    endfunction

    state_t           state_q, state_d;
    logic             gnt_q, gnt_d;
    logic             last_q, last_d;
    logic             grant;
    logic             rsp_load;
    logic [31:0]      rsp_rdata;
    logic [1:0]       rsp_resp;

    logic [1:0]       req_v, rsp_clr, cap, ovf_set;
    logic [1:0]       pend_q, pend_d;
    logic [1:0]       ovf_q, ovf_d;

    logic [ABITS-1:0] in_addr   [2];
    logic [31:0]      in_wdata  [2];
    logic [1:0]       in_op     [2];
    logic [ABITS-1:0] h_addr_q  [2];
    logic [31:0]      h_wdata_q [2];
    logic [1:0]       h_op_q    [2];
    logic [31:0]      rdata_q   [2];
    logic [1:0]       resp_q    [2];

    logic [ABITS-1:0] m_addr_q;
    logic [31:0]      m_wdata_q;
    logic [1:0]       m_op_q;

    assign in_addr[0]  = s0_addr;
    assign in_addr[1]  = s1_addr;
    assign in_wdata[0] = s0_wdata;
    assign in_wdata[1] = s1_wdata;
    assign in_op[0]    = s0_op;
    assign in_op[1]    = s1_op;

    assign req_v = {s1_req & op_valid(s1_op), s0_req & op_valid(s0_op)};

    always_comb begin
        rsp_clr = '0;
        if (state_q == RESP) rsp_clr[gnt_q] = 1'b1;
    end

    // A request landing in its own port's RESP cycle is a fresh capture, not an overflow.
    assign cap     = req_v & (~pend_q | rsp_clr);
    assign ovf_set = req_v & pend_q & ~rsp_clr;
    assign pend_d  = (pend_q & ~rsp_clr) | cap;
    assign ovf_d   = (ovf_q & ~{2{ovf_clr}}) | ovf_set;

`ifdef DMI_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^8'(TIMEOUT);
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        grant     = 1'b0;
        rsp_load  = 1'b0;
        rsp_rdata = m_rdata;
        rsp_resp  = m_resp;
`ifdef DMI_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pend_q != 2'b00) begin
                    grant   = 1'b1;
                    gnt_d   = (pend_q == 2'b11) ? ~last_q : pend_q[1];
                    last_d  = gnt_d;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef DMI_ARB_TIMEOUT_EN
                cnt_d   = 8'd0;
`endif
            end
            WAIT: begin
                if (m_ack) begin
                    rsp_load = 1'b1;
                    state_d  = RESP;
                end
`ifdef DMI_ARB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    rsp_load  = 1'b1;
                    rsp_rdata = 32'd0;
                    rsp_resp  = 2'b11;
                    state_d   = RESP;
                end
                cnt_d = cnt_q + 8'd1;
`endif
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge trst_n) begin
        if (!trst_n) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            pend_q     <= 2'b00;
            ovf_q      <= 2'b00;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_op_q     <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
            resp_q[0]  <= '0;
            resp_q[1]  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            if (grant) begin
                m_addr_q  <= h_addr_q[gnt_d];
                m_wdata_q <= h_wdata_q[gnt_d];
                m_op_q    <= h_op_q[gnt_d];
            end
            if (rsp_load) begin
                rdata_q[gnt_q] <= rsp_rdata;
                resp_q[gnt_q]  <= rsp_resp;
            end
        end
    end

`ifdef DMI_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge trst_n) begin
        if (!trst_n) cnt_q <= 8'd0;
        else         cnt_q <= cnt_d;
    end
`endif

    // Holding registers are qualified by pend, so they need no reset.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (cap[n]) begin
                h_addr_q[n]  <= in_addr[n];
                h_wdata_q[n] <= in_wdata[n];
                h_op_q[n]    <= in_op[n];
            end
        end
    end

    assign m_req    = (state_q == ISSUE);
    assign busy     = (state_q != IDLE);
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_op     = m_op_q;
    assign s0_ack   = rsp_clr[0];
    assign s1_ack   = rsp_clr[1];
    assign s0_rdata = rdata_q[0];
    assign s1_rdata = rdata_q[1];
    assign s0_resp  = resp_q[0];
    assign s1_resp  = resp_q[1];
    assign s0_ovf   = ovf_q[0];
    assign s1_ovf   = ovf_q[1];

endmodule

// File: tb/tb_dmi_arbiter.sv
// Bench for dmi_arbiter: directed steps plus randomized rounds against a request-level model.
module tb_dmi_arbiter;
    localparam int ABITS = 7;
    localparam int TO    = 16;

    logic             clk = 1'b0;
    logic             trst_n;
    logic             s0_req, s1_req, ovf_clr;
    logic [ABITS-1:0] s0_addr, s1_addr, m_addr;
    logic [31:0]      s0_wdata, s1_wdata, m_wdata;
    logic [1:0]       s0_op, s1_op, m_op;
    logic             s0_ack, s1_ack, s0_ovf, s1_ovf;
    logic [31:0]      s0_rdata, s1_rdata, m_rdata;
    logic [1:0]       s0_resp, s1_resp, m_resp;
    logic             m_req, m_ack, busy;

    always #5 clk = ~clk;

    dmi_arbiter #(.ABITS(ABITS), .TIMEOUT(TO)) dut (
        .clk(clk), .trst_n(trst_n),
        .s0_req(s0_req), .s0_addr(s0_addr), .s0_wdata(s0_wdata), .s0_op(s0_op),
        .s0_ack(s0_ack), .s0_rdata(s0_rdata), .s0_resp(s0_resp), .s0_ovf(s0_ovf),
        .s1_req(s1_req), .s1_addr(s1_addr), .s1_wdata(s1_wdata), .s1_op(s1_op),
        .s1_ack(s1_ack), .s1_rdata(s1_rdata), .s1_resp(s1_resp), .s1_ovf(s1_ovf),
        .ovf_clr(ovf_clr),
        .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_op(m_op),
        .m_rdata(m_rdata), .m_resp(m_resp), .m_ack(m_ack), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    logic [40:0] iss_q[$];
    logic [33:0] ack0_q[$], ack1_q[$], dm_q[$];

    bit          dm_auto = 1'b1;
    bit          dm_fixed = 1'b0;
    int          dm_delay_max = 3;
    int          inj_cnt = 0;
    logic [31:0] fix_rdata = 32'd0;
    logic [1:0]  fix_resp = 2'd0;
    bit          mdl_last = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transaction monitor
    always @(negedge clk) begin
        if (m_req === 1'b1)  iss_q.push_back({m_addr, m_wdata, m_op});
        if (s0_ack === 1'b1) ack0_q.push_back({s0_rdata, s0_resp});
        if (s1_ack === 1'b1) ack1_q.push_back({s1_rdata, s1_resp});
    end

    // DM responder: acks each m_req after 0..dm_delay_max WAIT cycles
    initial begin
        int          d;
        int          inj_seen;
        logic [31:0] rd;
        logic [1:0]  rs;
        inj_seen = 0;
        m_ack = 1'b0; m_rdata = '0; m_resp = '0;
        forever begin
            @(negedge clk);
            if (inj_cnt != inj_seen) begin
                inj_seen = inj_cnt;
                m_rdata = 32'h1234_5678; m_resp = 2'd0; m_ack = 1'b1;
                @(negedge clk);
                m_ack = 1'b0;
            end else if (m_req === 1'b1 && dm_auto) begin
                d = $urandom_range(0, dm_delay_max);
                repeat (1 + d) @(negedge clk);
                rd = dm_fixed ? fix_rdata : $urandom;
                rs = dm_fixed ? fix_resp : 2'($urandom_range(0, 3));
                m_rdata = rd; m_resp = rs; m_ack = 1'b1;
                dm_q.push_back({rd, rs});
                @(negedge clk);
                m_ack = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic drive_req(input int p, input logic [6:0] a, input logic [31:0] w,
                             input logic [1:0] op);
        if (p == 0) begin s0_req = 1'b1; s0_addr = a; s0_wdata = w; s0_op = op; end
        else        begin s1_req = 1'b1; s1_addr = a; s1_wdata = w; s1_op = op; end
    endtask

    task automatic send(input int p, input logic [6:0] a, input logic [31:0] w,
                        input logic [1:0] op);
        drive_req(p, a, w, op);
        @(negedge clk);
        s0_req = 1'b0; s1_req = 1'b0;
    endtask

    task automatic clear_q();
        iss_q.delete(); ack0_q.delete(); ack1_q.delete(); dm_q.delete();
    endtask

    task automatic do_reset();
        trst_n = 1'b0; s0_req = 1'b0; s1_req = 1'b0; ovf_clr = 1'b0;
        s0_addr = '0; s1_addr = '0; s0_wdata = '0; s1_wdata = '0; s0_op = '0; s1_op = '0;
        repeat (2) @(negedge clk);
        trst_n = 1'b1;
        @(negedge clk);
        mdl_last = 1'b1;
        clear_q();
    endtask

    task automatic wait_done(input int n0, input int n1);
        for (int i = 0; i < 300; i++) begin
            if (ack0_q.size() >= n0 && ack1_q.size() >= n1 && busy === 1'b0) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic rand_round();
        logic [6:0]  a[2];
        logic [31:0] w[2];
        logic [1:0]  op[2];
        bit          rq[2], v[2], do_ovf;
        int          op_p, p, n[2];
        int          order[$];
        logic [33:0] ackv;
        for (int i = 0; i < 2; i++) begin
            rq[i] = 1'($urandom_range(0, 1));
            op[i] = 2'($urandom_range(0, 3));
            a[i]  = 7'($urandom);
            w[i]  = $urandom;
            v[i]  = rq[i] && (op[i] == 2'd1 || op[i] == 2'd2);
        end
        op_p   = $urandom_range(0, 1);
        do_ovf = ($urandom_range(0, 2) == 0) && v[op_p];
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        clear_q();
        for (int i = 0; i < 2; i++) if (rq[i]) drive_req(i, a[i], w[i], op[i]);
        @(negedge clk);
        s0_req = 1'b0; s1_req = 1'b0;
        if (do_ovf) send(op_p, 7'($urandom), $urandom, 2'($urandom_range(1, 2)));
        if (v[0] && v[1]) begin
            order.push_back(int'(!mdl_last));
            order.push_back(int'(mdl_last));
        end else if (v[0]) begin
            order.push_back(0); mdl_last = 1'b0;
        end else if (v[1]) begin
            order.push_back(1); mdl_last = 1'b1;
        end
        wait_done(int'(v[0]), int'(v[1]));
        chk("rr_issue_count", 64'(iss_q.size()), 64'(order.size()));
        chk("rr_ack0_count", 64'(ack0_q.size()), 64'(v[0]));
        chk("rr_ack1_count", 64'(ack1_q.size()), 64'(v[1]));
        n[0] = 0; n[1] = 0;
        foreach (order[i]) begin
            p = order[i];
            if (i < iss_q.size()) chk("rr_issue", 64'(iss_q[i]), 64'({a[p], w[p], op[p]}));
            if (i < dm_q.size() && n[p] < ((p == 0) ? ack0_q.size() : ack1_q.size())) begin
                ackv = (p == 0) ? ack0_q[n[p]] : ack1_q[n[p]];
                chk("rr_ack_data", 64'(ackv), 64'(dm_q[i]));
            end
            n[p]++;
        end
        chk("rr_ovf0", 64'(s0_ovf), 64'(do_ovf && op_p == 0));
        chk("rr_ovf1", 64'(s1_ovf), 64'(do_ovf && op_p == 1));
    endtask

    initial begin
        int  lat;
        bit  busy_seen;
        do_reset();

        // Reset state
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_m_req", 64'(m_req), 64'd0);
        chk("rst_acks", 64'({s0_ack, s1_ack}), 64'd0);
        chk("rst_ovf", 64'({s0_ovf, s1_ovf}), 64'd0);
        chk("rst_m_bus", 64'({m_addr, m_op}), 64'd0);
        chk("rst_m_wdata", 64'(m_wdata), 64'd0);
        chk("rst_s_rdata", 64'({s0_rdata, s1_rdata}), 64'd0);
        chk("rst_s_resp", 64'({s0_resp, s1_resp}), 64'd0);

        // Single read, minimum latency
        dm_fixed = 1'b1; fix_rdata = 32'hDEAD_BEEF; fix_resp = 2'd0; dm_delay_max = 0;
        drive_req(0, 7'h11, 32'h0, 2'd1);
        @(negedge clk);
        s0_req = 1'b0;
        lat = 1;
        while (s0_ack !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
        chk("single_latency", 64'(lat), 64'd4);
        wait_done(1, 0);
        chk("single_issue_count", 64'(iss_q.size()), 64'd1);
        if (iss_q.size() > 0) chk("single_issue", 64'(iss_q[0]), 64'({7'h11, 32'h0, 2'd1}));
        chk("single_ack0_count", 64'(ack0_q.size()), 64'd1);
        if (ack0_q.size() > 0) chk("single_ack0", 64'(ack0_q[0]), 64'({32'hDEAD_BEEF, 2'd0}));
        chk("single_ack1_count", 64'(ack1_q.size()), 64'd0);
        chk("single_rdata_hold", 64'(s0_rdata), 64'h0DEAD_BEEF);

        // Simultaneous writes after reset: port 0 first
        do_reset();
        dm_fixed = 1'b0; dm_delay_max = 3;
        drive_req(0, 7'h21, 32'hAAAA_0000, 2'd2);
        drive_req(1, 7'h22, 32'hBBBB_0000, 2'd2);
        @(negedge clk);
        s0_req = 1'b0; s1_req = 1'b0;
        wait_done(1, 1);
        chk("sim_issue_count", 64'(iss_q.size()), 64'd2);
        if (iss_q.size() > 1) begin
            chk("sim_first", 64'(iss_q[0]), 64'({7'h21, 32'hAAAA_0000, 2'd2}));
            chk("sim_second", 64'(iss_q[1]), 64'({7'h22, 32'hBBBB_0000, 2'd2}));
        end
        if (dm_q.size() > 1 && ack0_q.size() > 0 && ack1_q.size() > 0) begin
            chk("sim_ack0", 64'(ack0_q[0]), 64'(dm_q[0]));
            chk("sim_ack1", 64'(ack1_q[0]), 64'(dm_q[1]));
        end
        // Port 0 alone, then another tie: port 1 now wins
        send(0, 7'h23, 32'h1, 2'd1);
        wait_done(2, 1);
        clear_q();
        drive_req(0, 7'h24, 32'hCCCC_0000, 2'd2);
        drive_req(1, 7'h25, 32'hDDDD_0000, 2'd2);
        @(negedge clk);
        s0_req = 1'b0; s1_req = 1'b0;
        wait_done(1, 1);
        chk("sim2_issue_count", 64'(iss_q.size()), 64'd2);
        if (iss_q.size() > 1) begin
            chk("sim2_first", 64'(iss_q[0]), 64'({7'h25, 32'hDDDD_0000, 2'd2}));
            chk("sim2_second", 64'(iss_q[1]), 64'({7'h24, 32'hCCCC_0000, 2'd2}));
        end

        // Overflow on port 1, then clear
        clear_q();
        drive_req(1, 7'h31, 32'h1111_1111, 2'd2);
        @(negedge clk);
        s1_wdata = 32'h2222_2222;
        @(negedge clk);
        s1_req = 1'b0;
        wait_done(0, 1);
        chk("ovf_issue_count", 64'(iss_q.size()), 64'd1);
        if (iss_q.size() > 0) chk("ovf_issue", 64'(iss_q[0]), 64'({7'h31, 32'h1111_1111, 2'd2}));
        chk("ovf_ack1_count", 64'(ack1_q.size()), 64'd1);
        chk("ovf_s1_set", 64'(s1_ovf), 64'd1);
        chk("ovf_s0_clear", 64'(s0_ovf), 64'd0);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_cleared", 64'(s1_ovf), 64'd0);
        // Clear and overflow together: set wins
        drive_req(1, 7'h32, 32'h3, 2'd1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        s1_req = 1'b0; ovf_clr = 1'b0;
        chk("ovf_set_wins", 64'(s1_ovf), 64'd1);
        wait_done(0, 2);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;

        // Ignored ops
        clear_q();
        busy_seen = 1'b0;
        send(0, 7'h40, 32'h5, 2'd0);
        send(0, 7'h41, 32'h6, 2'd3);
        send(1, 7'h42, 32'h7, 2'd3);
        repeat (6) begin @(negedge clk); busy_seen |= busy; end
        chk("ign_busy", 64'(busy_seen), 64'd0);
        chk("ign_issue_count", 64'(iss_q.size()), 64'd0);
        chk("ign_acks", 64'(ack0_q.size() + ack1_q.size()), 64'd0);

        // Error passthrough, re-capture in the RESP cycle
        clear_q();
        dm_fixed = 1'b1; fix_rdata = 32'hCAFE_0001; fix_resp = 2'd2;
        send(0, 7'h05, 32'h0, 2'd1);
        for (int i = 0; i < 50; i++) begin
            if (s0_ack === 1'b1) break;
            @(negedge clk);
        end
        chk("err_resp", 64'(s0_resp), 64'd2);
        send(0, 7'h06, 32'h5555_AAAA, 2'd2);
        wait_done(2, 0);
        chk("err_ovf", 64'(s0_ovf), 64'd0);
        chk("err_issue_count", 64'(iss_q.size()), 64'd2);
        if (iss_q.size() > 1) chk("err_recapture", 64'(iss_q[1]), 64'({7'h06, 32'h5555_AAAA, 2'd2}));
        if (ack0_q.size() > 0) chk("err_ack", 64'(ack0_q[0]), 64'({32'hCAFE_0001, 2'd2}));
        dm_fixed = 1'b0;

        // Async reset mid-transaction
        clear_q();
        dm_auto = 1'b0;
        send(1, 7'h50, 32'h9, 2'd1);
        for (int i = 0; i < 20; i++) begin
            if (m_req === 1'b1) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        trst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_ack", 64'({s0_ack, s1_ack}), 64'd0);
        @(negedge clk);
        trst_n = 1'b1;
        mdl_last = 1'b1;
        repeat (8) @(negedge clk);
        chk("arst_no_ack", 64'(ack0_q.size() + ack1_q.size()), 64'd0);
        chk("arst_idle", 64'(busy), 64'd0);

`ifdef DMI_ARB_TIMEOUT_EN
        // Timeout: DM silent
        clear_q();
        send(0, 7'h44, 32'h0, 2'd1);
        for (int i = 0; i < 20; i++) begin
            if (m_req === 1'b1) break;
            @(negedge clk);
        end
        lat = 0;
        while (s0_ack !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
        chk("to_latency", 64'(lat), 64'(TO + 1));
        chk("to_resp", 64'({s0_rdata, s0_resp}), 64'({32'd0, 2'b11}));
        repeat (2) @(negedge clk);
        inj_cnt++;
        repeat (6) @(negedge clk);
        chk("to_late_ack", 64'(ack0_q.size()), 64'd1);
        chk("to_idle", 64'(busy), 64'd0);
        mdl_last = 1'b0;
`endif
        dm_auto = 1'b1;

        // Randomized rounds
        for (int r = 0; r < 40; r++) rand_round();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
